// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues one outstanding imem request at a time,
// flushes wrong-path fetches on redirect and absorbs decode stalls.
module fetch_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      PCSel,
   input  logic [XLEN-1:0] BrTarget,
   input  logic [XLEN-1:0] JalrTarget,
   input  logic            id_stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_inst,
   output logic            if_id_valid
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      DROP,
      HOLD
   } state_t;

   state_t          state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] req_pc;
   logic [XLEN-1:0] hold_pc;
   logic [31:0]     hold_inst;
   logic [XLEN-1:0] target;
   logic            redirect;
   logic            ifid_free;

   assign redirect  = (PCSel == 2'b01) | (PCSel == 2'b10);
   assign target    = (PCSel == 2'b01) ? BrTarget
                                       : {JalrTarget[XLEN-1:1], 1'b0};
   assign ifid_free = ~if_id_valid | ~id_stall;
   assign imem_req  = (state == REQ) & ~rst;
   assign imem_addr = fetch_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= REQ;
         fetch_pc    <= RESET_PC;
         req_pc      <= '0;
         hold_pc     <= '0;
         hold_inst   <= NOP;
         if_id_pc    <= '0;
         if_id_inst  <= NOP;
         if_id_valid <= 1'b0;
      end else if (redirect) begin
         // Flush wins over a decode stall; any in-flight response is wrong-path.
         fetch_pc    <= target;
         if_id_valid <= 1'b0;
         unique case (state)
            REQ:  state <= imem_gnt ? DROP : REQ;
            WAIT: state <= imem_rvalid ? REQ : DROP;
            DROP: state <= imem_rvalid ? REQ : DROP;
            HOLD: state <= REQ;
         endcase
      end else begin
         if (~id_stall) begin
            if_id_valid <= 1'b0;
         end
         unique case (state)
            REQ: begin
               if (imem_gnt) begin
                  req_pc   <= fetch_pc;
                  fetch_pc <= fetch_pc + XLEN'(4);
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  if (ifid_free) begin
                     if_id_pc    <= req_pc;
                     if_id_inst  <= imem_rdata;
                     if_id_valid <= 1'b1;
                     state       <= REQ;
                  end else begin
                     hold_pc   <= req_pc;
                     hold_inst <= imem_rdata;
                     state     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (~id_stall) begin
                  if_id_pc    <= hold_pc;
                  if_id_inst  <= hold_inst;
                  if_id_valid <= 1'b1;
                  state       <= REQ;
               end
            end
            DROP: begin
               if (imem_rvalid) begin
                  state <= REQ;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus against a transaction-level
// model of program order, redirects and a variable-latency memory.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  PCSel;
   logic [31:0] BrTarget;
   logic [31:0] JalrTarget;
   logic        id_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_inst;
   logic        if_id_valid;

   fetch_stage #(
      .XLEN     (32),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .PCSel       (PCSel),
      .BrTarget    (BrTarget),
      .JalrTarget  (JalrTarget),
      .id_stall    (id_stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .if_id_pc    (if_id_pc),
      .if_id_inst  (if_id_inst),
      .if_id_valid (if_id_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } rsp_t;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          lat      = 1;
   int          gnt_cfg  = 1;
   bit          rand_mode = 1'b0;
   int          rst_age  = 0;
   int          deliveries = 0;
   rsp_t        mq[$];
   logic [31:0] alive[$];
   logic [31:0] exp_fetch = RESET_PC;
   int          gcyc[logic [31:0]];
   int          dcyc[logic [31:0]];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h00A5_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      int r;
      if (rand_mode) begin
         r          = int'($urandom_range(0, 15));
         PCSel      = (r < 2) ? 2'b01 : (r < 4) ? 2'b10 :
                      (r < 6) ? 2'b11 : 2'b00;
         BrTarget   = $urandom & 32'hFFFF_FFFC;
         JalrTarget = $urandom;
         id_stall   = ($urandom_range(0, 2) == 0);
         lat        = int'($urandom_range(1, 3));
      end
      case (gnt_cfg)
         0:       imem_gnt = 1'b0;
         1:       imem_gnt = 1'b1;
         default: imem_gnt = 1'($urandom_range(0, 1));
      endcase
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (mq.size() > 0) begin
         if (mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
         end
      end
   endtask

   // One clock: drive, check pre-edge outputs, clock, update model, check.
   task automatic step();
      logic        r, acc, rv, stl, redir, pv;
      logic [31:0] a, tgt, ppc, pinst, head;
      rsp_t        e;
      drive_inputs();
      #1;
      r     = rst;
      acc   = imem_req & imem_gnt;
      a     = imem_addr;
      rv    = imem_rvalid;
      stl   = id_stall;
      redir = !r && (PCSel == 2'b01 || PCSel == 2'b10);
      tgt   = (PCSel == 2'b01) ? BrTarget : (JalrTarget & 32'hFFFF_FFFE);
      pv    = if_id_valid;
      ppc   = if_id_pc;
      pinst = if_id_inst;
      if (r) chk("req_in_rst", 32'(imem_req), 32'd0);
      if (imem_req && !r) chk("imem_addr", imem_addr, exp_fetch);
      @(posedge clk);
      #1;
      cyc++;
      if (rv) void'(mq.pop_front());
      if (acc) begin
         e.addr = a;
         e.due  = cyc - 1 + lat;
         mq.push_back(e);
         gcyc[a] = cyc - 1;
      end
      if (r) begin
         rst_age = 0;
         alive.delete();
         exp_fetch = RESET_PC;
         chk("rst_valid", 32'(if_id_valid), 32'd0);
         chk("rst_pc", if_id_pc, 32'd0);
         chk("rst_inst", if_id_inst, NOP);
      end else begin
         rst_age++;
         if (acc && !redir) alive.push_back(a);
         if (redir) begin
            alive.delete();
            exp_fetch = tgt;
            chk("flush_valid", 32'(if_id_valid), 32'd0);
         end else begin
            if (acc) exp_fetch = a + 32'd4;
            if (pv && stl) begin
               chk("stall_keep_valid", 32'(if_id_valid), 32'd1);
               chk("stall_keep_pc", if_id_pc, ppc);
               chk("stall_keep_inst", if_id_inst, pinst);
            end else if (if_id_valid) begin
               head = (alive.size() > 0) ? alive.pop_front() : 32'hFFFF_FFFF;
               chk("deliver_pc", if_id_pc, head);
               chk("deliver_inst", if_id_inst, mem_word(if_id_pc));
               dcyc[if_id_pc] = cyc;
               deliveries++;
            end
         end
      end
      if (rst_age >= 4 && mq.size() > 0) begin
         chk("one_outstanding", 32'(imem_req), 32'd0);
      end
   endtask

   initial begin
      bit ok;
      int d0;
      rst        = 1'b1;
      PCSel      = 2'b00;
      BrTarget   = '0;
      JalrTarget = '0;
      id_stall   = 1'b0;
      imem_gnt   = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      @(posedge clk);
      #1;

      // Reset, then straight-line fetch with 1-cycle memory.
      step();
      step();
      rst = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         step();
         ok = (deliveries >= 3);
      end
      chk("seq_timeout", 32'(ok), 32'd1);
      chk("lat_0x0", 32'(dcyc[32'h0] - gcyc[32'h0]), 32'd2);
      chk("lat_0x4", 32'(dcyc[32'h4] - gcyc[32'h4]), 32'd2);
      chk("gap_0x4", 32'(gcyc[32'h4] - gcyc[32'h0]), 32'd2);
      chk("gap_0x8", 32'(gcyc[32'h8] - gcyc[32'h4]), 32'd2);

      // Decode stall while the 0x4 response lands: hold buffer.
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      step();
      id_stall = 1'b1;
      step();
      step();
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_ifid_pc", if_id_pc, 32'h0);
      step();
      step();
      step();
      chk("hold_still_pc", if_id_pc, 32'h0);
      chk("hold_still_valid", 32'(if_id_valid), 32'd1);
      id_stall = 1'b0;
      step();
      chk("release_pc", if_id_pc, 32'h4);
      chk("release_valid", 32'(if_id_valid), 32'd1);
      chk("release_req", 32'(imem_req), 32'd1);
      chk("release_addr", imem_addr, 32'h8);

      // Branch redirect while 0x8 is outstanding on slow memory.
      lat = 3;
      step();
      PCSel    = 2'b01;
      BrTarget = 32'h100;
      step();
      PCSel = 2'b00;
      chk("br_flush", 32'(if_id_valid), 32'd0);
      chk("br_drop_req", 32'(imem_req), 32'd0);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         step();
         ok = imem_req;
      end
      chk("br_req_timeout", 32'(ok), 32'd1);
      chk("br_addr", imem_addr, 32'h100);
      lat = 1;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         step();
         ok = if_id_valid;
      end
      chk("br_deliver_timeout", 32'(ok), 32'd1);
      chk("br_deliver_pc", if_id_pc, 32'h100);

      // JALR redirect in REQ without grant: odd target aligned, no drop.
      gnt_cfg    = 0;
      PCSel      = 2'b10;
      JalrTarget = 32'h203;
      step();
      PCSel = 2'b00;
      chk("jalr_req", 32'(imem_req), 32'd1);
      chk("jalr_addr", imem_addr, 32'h202);
      step();
      chk("jalr_no_drop", 32'(imem_req), 32'd1);
      gnt_cfg = 1;

      // PCSel=11 is sequential; redirect beats a decode stall.
      PCSel = 2'b11;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         step();
         ok = if_id_valid;
      end
      chk("sel11_timeout", 32'(ok), 32'd1);
      chk("sel11_pc", if_id_pc, 32'h202);
      id_stall = 1'b1;
      PCSel    = 2'b01;
      BrTarget = 32'h300;
      step();
      chk("stall_flush", 32'(if_id_valid), 32'd0);
      PCSel    = 2'b00;
      id_stall = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 12 && !ok; i++) begin
         step();
         ok = if_id_valid;
      end
      chk("stall_flush_timeout", 32'(ok), 32'd1);
      chk("stall_flush_pc", if_id_pc, 32'h300);

      // Reset in WAIT with a late response arriving after release.
      lat = 3;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         step();
         ok = imem_req;
      end
      chk("rstw_req_timeout", 32'(ok), 32'd1);
      step();
      rst = 1'b1;
      step();
      step();
      rst     = 1'b0;
      gnt_cfg = 0;
      step();
      chk("rstw_valid", 32'(if_id_valid), 32'd0);
      chk("rstw_req", 32'(imem_req), 32'd1);
      chk("rstw_addr", imem_addr, RESET_PC);
      lat     = 1;
      gnt_cfg = 1;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         step();
         ok = if_id_valid;
      end
      chk("rstw_timeout", 32'(ok), 32'd1);
      chk("rstw_pc", if_id_pc, RESET_PC);
      chk("rstw_inst", if_id_inst, mem_word(RESET_PC));

      // Random redirects, stalls, grants and latencies.
      d0        = deliveries;
      rand_mode = 1'b1;
      gnt_cfg   = 2;
      for (int i = 0; i < 400; i++) step();
      rand_mode = 1'b0;
      PCSel     = 2'b00;
      id_stall  = 1'b0;
      gnt_cfg   = 1;
      lat       = 1;
      for (int i = 0; i < 8; i++) step();
      chk("rand_progress", 32'(deliveries > d0 + 20), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of branch resolution. Owns the PC register and consumes the 2-bit PCSel redirect code.
- Issues one-outstanding requests to instruction memory and delivers {pc, inst, valid} to the IF/ID register.
- Flushes wrong-path instructions on redirect and absorbs decode stalls with a 1-entry hold buffer.

Parameters:
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- PCSel  in  2  00 seq, 01 branch/jal taken, 10 jalr, 11 treated as 00
- BrTarget  in  XLEN  pc+imm target, used when PCSel=01
- JalrTarget  in  XLEN  rs1+imm target, used when PCSel=10
- id_stall  in  1  decode cannot accept; IF/ID holds
- imem_req  out  1  request valid
- imem_addr  out  XLEN  request address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; arrives >=1 cycle after grant
- imem_rdata  in  32  response instruction
- if_id_pc  out  XLEN  PC of delivered instruction
- if_id_inst  out  32  delivered instruction
- if_id_valid  out  1  IF/ID holds a valid instruction

Behaviour:
- Registers:
  - fetch_pc: next request address
  - req_pc: address of the outstanding request
  - hold_{pc,inst}: 1-entry hold buffer
  - state: REQ, WAIT, DROP, HOLD
  - IF/ID output registers
- Reset (any cycle, including mid-transaction):
  - fetch_pc=RESET_PC, state=REQ, if_id_valid=0, if_id_pc=0, if_id_inst=32'h0000_0013 (nop), hold cleared
  - imem_req=0 during any cycle rst=1
  - A response arriving after reset for a pre-reset request is ignored; in REQ state rvalid is don't-care
- redirect = (PCSel==01)|(PCSel==10). Target is BrTarget, or JalrTarget with bit0 cleared.
- imem_req = (state==REQ) & ~rst; imem_addr = fetch_pc (combinational).
- Redirect has priority over everything except rst. On the redirect cycle:
  - fetch_pc<=target; if_id_valid<=0 next cycle (flush, even if id_stall=1); hold buffer discarded.
  - REQ with gnt=1 (wrong-path request accepted) -> DROP.
  - REQ with gnt=0 -> stay REQ.
  - WAIT with rvalid=0 -> DROP; WAIT with rvalid=1 -> REQ, response discarded.
  - DROP -> stays DROP until rvalid; HOLD -> REQ.
- No redirect:
  - REQ: on gnt, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^XLEN), go to WAIT.
  - WAIT: on rvalid and IF/ID free (if_id_valid=0 or id_stall=0), load IF/ID={req_pc, rdata}, valid=1, go to REQ. On rvalid with IF/ID full and stalled, capture into hold buffer, go to HOLD.
  - HOLD: when id_stall=0, move hold to IF/ID, valid=1, go to REQ.
  - DROP: on rvalid, discard, go to REQ.
- IF/ID update when nothing new is delivered: id_stall=1 keeps contents; id_stall=0 sets if_id_valid<=0.
- Latency: best case gnt in cycle N, rvalid in N+1, IF/ID valid in N+2; next request issues in N+2. Throughput is 1 instruction per 2 cycles with 1-cycle memory.
- Exactly one request outstanding at any time; imem_req is never asserted in WAIT, DROP or HOLD.

Test Plan:
- Reset release, 1-cycle memory, gnt always 1, no redirects -> addresses 0x0,0x4,0x8 issued every 2 cycles; IF/ID shows pc 0x0,0x4,0x8 with correct inst; valid alternates 1/0.
- Response for 0x4 arrives while id_stall=1 and IF/ID holds 0x0 -> HOLD. Release stall 3 cycles later -> IF/ID=0x4 the next cycle, no duplicate or lost instruction, next request 0x8.
- PCSel=01, BrTarget=0x100 while request 0x8 is outstanding -> IF/ID valid=0 next cycle; 0x8 response dropped; next imem_addr=0x100.
- PCSel=10, JalrTarget=0x203 in REQ with gnt=0 -> next imem_addr=0x202; no drop state entered.
- PCSel=11 -> behaves exactly as 00; redirect asserted together with id_stall=1 -> flush wins, if_id_valid=0.
- rst asserted while in WAIT -> next cycles imem_req=0, if_id_valid=0; fetch resumes at RESET_PC; late rvalid ignored.
